// File: rtl/multi_input_gate_pipe.sv
// Registered N-input bitwise gate with run-time function select, valid/ready
// handshake and a saturating count of nonzero results delivered downstream.
module multi_input_gate_pipe #(
  parameter int N_IN  = 3,
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [2:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    hit_clr,
  output logic [CNT_W-1:0]        hit_cnt
);

  localparam int ONES_W = $clog2(N_IN + 1);

  logic [WIDTH-1:0]  r_or;
  logic [WIDTH-1:0]  r_and;
  logic [WIDTH-1:0]  r_xor;
  logic [WIDTH-1:0]  r_maj;
  logic [WIDTH-1:0]  result;
  logic [ONES_W-1:0] ones;
  logic              accept;
  logic              xfer;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    r_or  = '0;
    r_and = '1;
    r_xor = '0;
    for (int k = 0; k < N_IN; k++) begin
      r_or  = r_or  | in_data[k*WIDTH +: WIDTH];
      r_and = r_and & in_data[k*WIDTH +: WIDTH];
      r_xor = r_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  // Majority is strict: an even split of ones and zeros yields 0.
  always_comb begin
    r_maj = '0;
    ones  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int k = 0; k < N_IN; k++) begin
        ones = ones + ONES_W'(in_data[k*WIDTH + b]);
      end
      r_maj[b] = (2 * int'(ones)) > N_IN;
    end
  end

  always_comb begin
    result = '0;
    case (mode)
      3'd0:    result = r_or;
      3'd1:    result = r_and;
      3'd2:    result = r_xor;
      3'd3:    result = ~r_or;
      3'd4:    result = ~r_and;
      3'd5:    result = ~r_xor;
      3'd6:    result = r_maj;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (hit_clr) begin
      hit_cnt <= '0;
    end else if (xfer && (out_data != '0) && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_input_gate_pipe.sv
// Directed bench for multi_input_gate_pipe: a 3-input instance, a 4-input
// instance for tie-breaking, and a 3-bit counter instance for saturation.
module tb_multi_input_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_data3;
  logic [3:0] in_data4;
  logic [2:0] mode;
  logic       out_ready;
  logic       hit_clr;

  logic       in_ready_a, out_valid_a;
  logic [0:0] out_data_a;
  logic [7:0] hit_cnt_a;
  logic       in_ready_q, out_valid_q;
  logic [0:0] out_data_q;
  logic [7:0] hit_cnt_q;
  logic       in_ready_s, out_valid_s;
  logic [0:0] out_data_s;
  logic [2:0] hit_cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_input_gate_pipe #(.N_IN(3), .WIDTH(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data3), .mode(mode), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .hit_clr(hit_clr), .hit_cnt(hit_cnt_a)
  );

  multi_input_gate_pipe #(.N_IN(4), .WIDTH(1), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_q),
    .in_data(in_data4), .mode(mode), .out_valid(out_valid_q), .out_ready(out_ready),
    .out_data(out_data_q), .hit_clr(hit_clr), .hit_cnt(hit_cnt_q)
  );

  multi_input_gate_pipe #(.N_IN(3), .WIDTH(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data3), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .hit_clr(hit_clr), .hit_cnt(hit_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle accept; on return the result is visible and in_valid is low.
  task automatic send(input logic [2:0] m, input logic [2:0] d3, input logic [3:0] d4);
    mode     = m;
    in_data3 = d3;
    in_data4 = d4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data3  = '0;
    in_data4  = '0;
    mode      = 3'd0;
    out_ready = 1'b1;
    hit_clr   = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_out_data",  32'(out_data_a),  0);
    chk("rst_hit_cnt",   32'(hit_cnt_a),   0);
    chk("rst_in_ready",  32'(in_ready_a),  1);
    rst_n = 1'b1;
    tick();

    // OR across all eight 3-bit patterns, back to back
    for (int v = 0; v < 8; v++) begin
      mode     = 3'd0;
      in_data3 = 3'(v);
      in_valid = 1'b1;
      tick();
      chk($sformatf("or_valid_%0d", v), 32'(out_valid_a), 1);
      chk($sformatf("or_data_%0d", v),  32'(out_data_a),  (v != 0) ? 1 : 0);
    end
    in_valid = 1'b0;
    tick();
    chk("or_drain_valid", 32'(out_valid_a), 0);
    chk("or_hit_cnt",     32'(hit_cnt_a),   7);
    chk("or_hold_data",   32'(out_data_a),  1);

    // function table, with the 4-input instance checking majority ties
    send(3'd6, 3'b011, 4'b0011);
    chk("maj_011",  32'(out_data_a), 1);
    chk("maj4_tie", 32'(out_data_q), 0);
    send(3'd6, 3'b100, 4'b0111);
    chk("maj_100",  32'(out_data_a), 0);
    chk("maj4_0111", 32'(out_data_q), 1);
    send(3'd2, 3'b111, 4'b0000);
    chk("xor_111",  32'(out_data_a), 1);
    send(3'd7, 3'b111, 4'b1111);
    chk("rsv_111",  32'(out_data_a), 0);
    chk("rsv4_1111", 32'(out_data_q), 0);
    send(3'd1, 3'b111, 4'b1110);
    chk("and_111",  32'(out_data_a), 1);
    chk("and4_1110", 32'(out_data_q), 0);
    send(3'd3, 3'b000, 4'b0000);
    chk("nor_000",  32'(out_data_a), 1);
    send(3'd4, 3'b111, 4'b0111);
    chk("nand_111", 32'(out_data_a), 0);
    chk("nand4_0111", 32'(out_data_q), 1);
    send(3'd5, 3'b110, 4'b0111);
    chk("xnor_110", 32'(out_data_a), 1);
    chk("xnor4_0111", 32'(out_data_q), 0);
    tick();

    // backpressure: result held while downstream stalls
    send(3'd0, 3'b001, 4'b0000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data3  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_in_ready_%0d", i),  32'(in_ready_a),  0);
      chk($sformatf("stall_out_valid_%0d", i), 32'(out_valid_a), 1);
      chk($sformatf("stall_out_data_%0d", i),  32'(out_data_a),  1);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready_a), 1);
    tick();
    in_valid = 1'b0;
    chk("swap_out_valid", 32'(out_valid_a), 1);
    chk("swap_out_data",  32'(out_data_a),  0);
    tick();
    chk("swap_drain_valid", 32'(out_valid_a), 0);

    // saturation on the 3-bit counter
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
    chk("clr_sat", 32'(hit_cnt_s), 0);
    chk("clr_main", 32'(hit_cnt_a), 0);
    mode     = 3'd0;
    in_data3 = 3'b111;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_cnt",  32'(hit_cnt_s), 7);
    chk("main_cnt9", 32'(hit_cnt_a), 9);

    // clear beats a simultaneous nonzero transfer
    send(3'd0, 3'b111, 4'b0000);
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
    chk("clr_win_sat",  32'(hit_cnt_s), 0);
    chk("clr_win_main", 32'(hit_cnt_a), 0);
    chk("clr_win_valid", 32'(out_valid_a), 0);

    // reset during a stall
    send(3'd0, 3'b001, 4'b0000);
    tick();
    chk("pre_rst_cnt", 32'(hit_cnt_a), 1);
    send(3'd0, 3'b001, 4'b0000);
    out_ready = 1'b0;
    tick();
    chk("pre_rst_stall", 32'(in_ready_a), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid_a), 0);
    chk("rst_mid_cnt",   32'(hit_cnt_a),   0);
    chk("rst_mid_data",  32'(out_data_a),  0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_in_ready", 32'(in_ready_a), 1);
    tick();
    chk("rst_rel_valid", 32'(out_valid_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
